// File: rtl/aes_mix_pkg.sv
// Shared definitions for the iterative AES MixColumns unit.
//   - FSM state encoding
//   - GF(2^8) helpers: xtime2 (multiply by 2, reduction 0x1b) and xtimeN
//   - MixColumns coefficient rows, element j multiplies column byte (i+j) mod 4
//   - step counter width helper
package aes_mix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row coefficients indexed by rotation offset j: [0] applies to c_i, [3] to c_(i+3)
    localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    function automatic logic [7:0] xtime2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply b by an arbitrary constant n via repeated doubling
    function automatic logic [7:0] xtimeN(input logic [7:0] b, input logic [7:0] n);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (n[i]) acc = acc ^ p;
            p = xtime2(p);
        end
        return acc;
    endfunction

    function automatic int unsigned step_width(input int unsigned nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

// File: rtl/aes_mix_byte.sv
// One output byte of a forward or inverse MixColumns column.
//   col      : packed column {c3,c2,c1,c0}
//   enc      : 1 = forward, 0 = inverse
//   idx      : output byte index i (0..3)
//   out_byte : o_i = sum_j coef[j] * c_((i+j) mod 4)
module aes_mix_byte
    import aes_mix_pkg::*;
(
    input  logic [31:0] col,
    input  logic        enc,
    input  logic [1:0]  idx,
    output logic [7:0]  out_byte
);

    always_comb begin
        logic [1:0] sel;
        logic [7:0] coef;
        sel      = '0;
        coef     = '0;
        out_byte = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            sel      = idx + 2'(j);
            coef     = enc ? FWD_COEF[j] : INV_COEF[j];
            out_byte = out_byte ^ xtimeN(col[{sel, 3'b000} +: 8], coef);
        end
    end

endmodule

// File: rtl/aes_v3_mix_iter.sv
// Iterative AES MixColumns unit behind a valid/ready handshake.
// Captures a column, computes BPC result bytes per cycle over NSTEP cycles,
// then pulses ready for one cycle with the full result.
//   clock, reset (async active-low), flush/flush_data (sync scrub)
//   valid : request, held until ready
//   rs1   : byte0 = rs1[7:0], byte1 = rs1[15:8]
//   rs2   : byte2 = rs2[23:16], byte3 = rs2[31:24]
//   enc   : 1 = forward, 0 = inverse
//   ready : one-cycle completion pulse
//   result: {o3,o2,o1,o0} during ready, zero otherwise
module aes_v3_mix_iter
    import aes_mix_pkg::*;
#(
    parameter int unsigned BPC = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);

    localparam int unsigned NSTEP = 4 / BPC;
    localparam int unsigned SW    = step_width(NSTEP);

    if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
        $error("aes_v3_mix_iter: BPC must be 1, 2 or 4");
    end

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q;
    logic [31:0]     op_q;
    logic            enc_q;
    logic [31:0]     res_q;

    logic [1:0]      lane_idx [BPC];
    logic [7:0]      lane_out [BPC];

    // Only the two low bytes of rs1 and two high bytes of rs2 carry operands
    logic            unused_operand_bits;
    assign unused_operand_bits = ^{rs1[31:16], rs2[15:0]};

    for (genvar l = 0; l < BPC; l++) begin : g_lane
        assign lane_idx[l] = 2'(step_q * BPC + l);
        aes_mix_byte u_byte (
            .col      (op_q),
            .enc      (enc_q),
            .idx      (lane_idx[l]),
            .out_byte (lane_out[l])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: if (valid) state_d = BUSY;
            BUSY: begin
                if (!valid)                         state_d = IDLE;
                else if (step_q == SW'(NSTEP - 1)) state_d = DONE;
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_q <= '0;
            op_q   <= '0;
            enc_q  <= 1'b0;
            res_q  <= '0;
        end else if (flush) begin
            step_q <= '0;
            op_q   <= flush_data;
            enc_q  <= 1'b0;
            res_q  <= flush_data;
        end else begin
            case (state_q)
                IDLE: if (valid) begin
                    op_q   <= {rs2[31:16], rs1[15:0]};
                    enc_q  <= enc;
                    step_q <= '0;
                end
                BUSY: begin
                    if (!valid) begin
                        res_q  <= '0;
                        step_q <= '0;
                    end else begin
                        for (int unsigned l = 0; l < BPC; l++) begin
                            res_q[{lane_idx[l], 3'b000} +: 8] <= lane_out[l];
                        end
                        step_q <= step_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = res_q & {32{ready}};

endmodule

// File: tb/tb_aes_v3_mix_iter.sv
module tb_aes_v3_mix_iter;
    import aes_mix_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      fdata = '0;
    logic [2:0]       flush_v = '0;
    logic [2:0]       valid_v = '0;
    logic [2:0][31:0] rs1_v = '0;
    logic [2:0][31:0] rs2_v = '0;
    logic [2:0]       enc_v = '0;
    logic             r0, r1, r2;
    logic [31:0]      q0, q1, q2;
    logic [2:0]       ready_v;
    logic [2:0][31:0] result_v;

    int checks = 0;
    int errors = 0;

    assign ready_v  = {r2, r1, r0};
    assign result_v = {q2, q1, q0};

    always #5 clk = ~clk;

    aes_v3_mix_iter #(.BPC(1)) dut1 (
        .clock(clk), .reset(rst_n), .flush(flush_v[0]), .flush_data(fdata),
        .valid(valid_v[0]), .rs1(rs1_v[0]), .rs2(rs2_v[0]), .enc(enc_v[0]),
        .ready(r0), .result(q0));
    aes_v3_mix_iter #(.BPC(2)) dut2 (
        .clock(clk), .reset(rst_n), .flush(flush_v[1]), .flush_data(fdata),
        .valid(valid_v[1]), .rs1(rs1_v[1]), .rs2(rs2_v[1]), .enc(enc_v[1]),
        .ready(r1), .result(q1));
    aes_v3_mix_iter #(.BPC(4)) dut4 (
        .clock(clk), .reset(rst_n), .flush(flush_v[2]), .flush_data(fdata),
        .valid(valid_v[2]), .rs1(rs1_v[2]), .rs2(rs2_v[2]), .enc(enc_v[2]),
        .ready(r2), .result(q2));

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        enc;
        logic [31:0] exp;
    } vec_t;

    // Polynomial product followed by long division by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product: o_i = sum_j row[(j-i) mod 4] * c_j
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic e);
        logic [7:0] c [4];
        logic [7:0] row [4];
        logic [7:0] o;
        logic [31:0] r;
        c[0] = a[7:0]; c[1] = a[15:8]; c[2] = b[23:16]; c[3] = b[31:24];
        if (e) begin row[0] = 8'd2;  row[1] = 8'd3;  row[2] = 8'd1;  row[3] = 8'd1; end
        else   begin row[0] = 8'd14; row[1] = 8'd11; row[2] = 8'd13; row[3] = 8'd9; end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            o = '0;
            for (int j = 0; j < 4; j++) o = o ^ gmul(row[(j - i + 4) % 4], c[j]);
            r[8*i +: 8] = o;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one request on instance k and wait (bounded) for ready.
    // lat = number of rising edges from first valid-high edge to ready; -1 on timeout.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input bit hold, input bit scramble,
                          output logic [31:0] res, output int lat);
        int leak;
        leak = 0;
        lat  = -1;
        res  = '0;
        @(negedge clk);
        rs1_v[k] = a; rs2_v[k] = b; enc_v[k] = e; valid_v[k] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ready_v[k]) begin
                lat = c;
                res = result_v[k];
                break;
            end
            if (result_v[k] !== 32'h0) leak++;
            if (scramble && c == 1) begin
                rs1_v[k] = ~a; rs2_v[k] = ~b; enc_v[k] = ~e;
            end
        end
        check("leak", 32'(leak), 32'h0);
        if (!hold) begin
            @(negedge clk);
            valid_v[k] = 1'b0;
        end
    endtask

    initial begin
        vec_t vecs [5];
        logic [31:0] res, a, b;
        logic e;
        int lat, cnt;

        vecs[0] = '{32'h000013db, 32'h45530000, 1'b1, 32'hbca14d8e};
        vecs[1] = '{32'h00004d8e, 32'hbca10000, 1'b0, 32'h455313db};
        vecs[2] = '{32'h00000af2, 32'h5c220000, 1'b1, 32'h9d58dc9f};
        vecs[3] = '{32'h0000c6c6, 32'hc6c60000, 1'b1, 32'hc6c6c6c6};
        vecs[4] = '{32'h00000101, 32'h01010000, 1'b1, 32'h01010101};

        // Reset state
        #12;
        check("rst_ready", 32'(ready_v), 32'h0);
        check("rst_result0", result_v[0], 32'h0);
        check("rst_op", dut1.op_q, 32'h0);
        check("rst_res", dut1.res_q, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Table vectors on every BPC
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 5; v++) begin
                run_op(k, vecs[v].rs1, vecs[v].rs2, vecs[v].enc, 1'b0, 1'b0, res, lat);
                check($sformatf("vec%0d_bpc%0d", v, 1 << k), res, vecs[v].exp);
                check($sformatf("lat%0d_bpc%0d", v, 1 << k), 32'(lat), 32'((4 >> k) + 1));
            end
        end

        // Randomized against the model
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 15; n++) begin
                a = $urandom; b = $urandom; e = 1'($urandom_range(0, 1));
                run_op(k, a, b, e, 1'b0, 1'b0, res, lat);
                check($sformatf("rand_bpc%0d", 1 << k), res, model(a, b, e));
                check($sformatf("rand_lat_bpc%0d", 1 << k), 32'(lat), 32'((4 >> k) + 1));
            end
        end

        // Operand changes during BUSY are ignored
        for (int k = 0; k < 3; k++) begin
            run_op(k, vecs[2].rs1, vecs[2].rs2, 1'b1, 1'b0, 1'b1, res, lat);
            check($sformatf("scramble_bpc%0d", 1 << k), res, 32'h9d58dc9f);
        end

        // Back-to-back: valid held through DONE starts a new operation
        for (int k = 0; k < 3; k += 2) begin
            run_op(k, vecs[0].rs1, vecs[0].rs2, 1'b1, 1'b1, 1'b0, res, lat);
            check("b2b_first", res, 32'hbca14d8e);
            run_op(k, vecs[1].rs1, vecs[1].rs2, 1'b0, 1'b0, 1'b0, res, lat);
            check("b2b_second", res, 32'h455313db);
            check("b2b_lat", 32'(lat), 32'((4 >> k) + 2));
        end

        // Abort after one BUSY cycle (BPC=1)
        @(negedge clk);
        rs1_v[0] = vecs[0].rs1; rs2_v[0] = vecs[0].rs2; enc_v[0] = 1'b1; valid_v[0] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        valid_v[0] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ready_v[0]) cnt++;
        end
        check("abort_noready", 32'(cnt), 32'h0);
        check("abort_res_clr", dut1.res_q, 32'h0);
        run_op(0, vecs[4].rs1, vecs[4].rs2, 1'b1, 1'b0, 1'b0, res, lat);
        check("after_abort", res, 32'h01010101);

        // Flush mid-BUSY (BPC=1)
        @(negedge clk);
        rs1_v[0] = vecs[2].rs1; rs2_v[0] = vecs[2].rs2; enc_v[0] = 1'b1; valid_v[0] = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        fdata = 32'ha5a5a5a5; flush_v[0] = 1'b1;
        @(posedge clk); #1;
        flush_v[0] = 1'b0; valid_v[0] = 1'b0;
        check("flush_state", 32'(dut1.state_q), 32'(IDLE));
        check("flush_op", dut1.op_q, 32'ha5a5a5a5);
        check("flush_res", dut1.res_q, 32'ha5a5a5a5);
        check("flush_step", 32'(dut1.step_q), 32'h0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ready_v[0]) cnt++;
        end
        check("flush_noready", 32'(cnt), 32'h0);
        run_op(0, vecs[1].rs1, vecs[1].rs2, 1'b0, 1'b0, 1'b0, res, lat);
        check("after_flush", res, 32'h455313db);

        // Flush coincident with valid in IDLE: no capture
        @(negedge clk);
        fdata = 32'h5a5a5a5a; flush_v[0] = 1'b1; valid_v[0] = 1'b1;
        rs1_v[0] = vecs[0].rs1; rs2_v[0] = vecs[0].rs2;
        @(posedge clk); #1;
        flush_v[0] = 1'b0; valid_v[0] = 1'b0;
        check("flush_vs_valid_state", 32'(dut1.state_q), 32'(IDLE));
        check("flush_vs_valid_op", dut1.op_q, 32'h5a5a5a5a);

        // Async reset mid-BUSY, between edges
        @(negedge clk);
        rs1_v[0] = vecs[0].rs1; rs2_v[0] = vecs[0].rs2; enc_v[0] = 1'b1; valid_v[0] = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("areset_busy_state", 32'(dut1.state_q), 32'(IDLE));
        check("areset_busy_op", dut1.op_q, 32'h0);
        check("areset_busy_ready", 32'(ready_v[0]), 32'h0);
        check("areset_busy_result", result_v[0], 32'h0);
        @(negedge clk); valid_v[0] = 1'b0; rst_n = 1'b1;

        // Async reset during the ready cycle (BPC=4)
        run_op(2, vecs[0].rs1, vecs[0].rs2, 1'b1, 1'b1, 1'b0, res, lat);
        check("pre_reset_result", res, 32'hbca14d8e);
        #1 rst_n = 1'b0; #1;
        check("areset_done_ready", 32'(ready_v[2]), 32'h0);
        check("areset_done_result", result_v[2], 32'h0);
        @(negedge clk); valid_v[2] = 1'b0; rst_n = 1'b1;
        run_op(2, vecs[3].rs1, vecs[3].rs2, 1'b1, 1'b0, 1'b0, res, lat);
        check("after_reset", res, 32'hc6c6c6c6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
